// File: rtl/voice_mixer_pkg.sv
// Shared types and default constants for the voice mixer.
// The VOICE_MIXER_SATURATE_EN macro selects clamping or scaling in mix_limiter.
package voice_mixer_pkg;

    localparam int unsigned DEF_NUM_VOICES = 3;
    localparam int unsigned DEF_SAMPLE_W   = 16;
    localparam int unsigned DEF_TIMEOUT    = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_SUM,
        S_OUT
    } state_e;

    typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/voice_mixer_limiter.sv
// Combinational reduction of the full-width voice sum to one output sample.
// VOICE_MIXER_SATURATE_EN defined: clamp with clip flag; undefined: scale down by $clog2(NUM_VOICES).
module mix_limiter #(
    parameter int unsigned SUM_W    = 18,
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic signed [SUM_W-1:0]    sum_i,
    output logic signed [SAMPLE_W-1:0] sample_c_o,
    output logic                       clip_c_o
);

`ifdef VOICE_MIXER_SATURATE_EN
    localparam logic signed [SUM_W-1:0] MAX_V = {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_V = {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    always_comb begin
        sample_c_o = SAMPLE_W'(sum_i);
        clip_c_o   = 1'b0;
        if (sum_i > MAX_V) begin
            sample_c_o = SAMPLE_W'(MAX_V);
            clip_c_o   = 1'b1;
        end else if (sum_i < MIN_V) begin
            sample_c_o = SAMPLE_W'(MIN_V);
            clip_c_o   = 1'b1;
        end
    end
`else
    // SUM_W carries $clog2(NUM_VOICES)+1 guard bits; dropping all but the sign bit scales by 1/2^clog2.
    localparam int unsigned SHIFT = SUM_W - SAMPLE_W - 1;

    always_comb begin
        sample_c_o = SAMPLE_W'(sum_i >>> SHIFT);
        clip_c_o   = 1'b0;
    end
`endif

endmodule

// File: rtl/voice_mixer.sv
// Collects one sample per active voice, sums them and emits a limited mixed sample.
// Limiting mode is chosen by the VOICE_MIXER_SATURATE_EN macro (see mix_limiter).
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int unsigned NUM_VOICES = DEF_NUM_VOICES,
    parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           generate_next_sample,
    input  logic [NUM_VOICES-1:0]          voice_active,
    input  logic [NUM_VOICES-1:0]          voice_ready,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    output logic [SAMPLE_W-1:0]            mix_sample,
    output logic                           mix_valid,
    output logic                           busy,
    output logic                           clip,
    output logic                           timeout
);

    localparam int unsigned SUM_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e                     state_q;
    logic [NUM_VOICES-1:0]      pending_q;
    logic [NUM_VOICES-1:0]      pending_d;
    logic [NUM_VOICES-1:0]      capture_c;
    logic signed [SAMPLE_W-1:0] latched_q [NUM_VOICES];
    logic [CNT_W-1:0]           cnt_q;
    logic                       forced_q;
    logic signed [SUM_W-1:0]    sum_c;
    logic signed [SAMPLE_W-1:0] lim_sample_c;
    logic                       lim_clip_c;
    logic [SAMPLE_W-1:0]        mix_sample_q;
    logic                       mix_valid_q;
    logic                       busy_q;
    logic                       clip_q;
    logic                       timeout_q;

    // First ready pulse of each still-pending voice wins.
    always_comb begin
        capture_c = '0;
        if (state_q == S_COLLECT) begin
            capture_c = voice_ready & pending_q;
        end
        pending_d = pending_q & ~capture_c;
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            sum_c = sum_c + SUM_W'(latched_q[i]);
        end
    end

    mix_limiter #(
        .SUM_W    (SUM_W),
        .SAMPLE_W (SAMPLE_W)
    ) u_limiter (
        .sum_i      (sum_c),
        .sample_c_o (lim_sample_c),
        .clip_c_o   (lim_clip_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            cnt_q        <= '0;
            forced_q     <= 1'b0;
            mix_sample_q <= '0;
            mix_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            clip_q       <= 1'b0;
            timeout_q    <= 1'b0;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                latched_q[i] <= '0;
            end
        end else begin
            mix_valid_q <= 1'b0;
            clip_q      <= 1'b0;
            timeout_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (generate_next_sample) begin
                        pending_q <= voice_active;
                        cnt_q     <= '0;
                        forced_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_COLLECT;
                        for (int i = 0; i < int'(NUM_VOICES); i++) begin
                            latched_q[i] <= '0;
                        end
                    end
                end
                S_COLLECT: begin
                    for (int i = 0; i < int'(NUM_VOICES); i++) begin
                        if (capture_c[i]) begin
                            latched_q[i] <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
                        end
                    end
                    pending_q <= pending_d;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    // Leave one cycle after the mask empties, or on the last allowed cycle.
                    if (pending_q == '0) begin
                        state_q <= S_SUM;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        forced_q <= |pending_d;
                        state_q  <= S_SUM;
                    end
                end
                S_SUM: begin
                    mix_sample_q <= lim_sample_c;
                    clip_q       <= lim_clip_c;
                    timeout_q    <= forced_q;
                    mix_valid_q  <= 1'b1;
                    state_q      <= S_OUT;
                end
                S_OUT: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mix_sample = mix_sample_q;
    assign mix_valid  = mix_valid_q;
    assign busy       = busy_q;
    assign clip       = clip_q;
    assign timeout    = timeout_q;

endmodule
